// File: rtl/toast_alu_issue.sv
// toast_alu_issue: registered RV32I decode/issue stage sitting between the
// register-file read and execute. Selects the ALU operation and operands,
// derives branch/writeback sideband and presents it all from one pipeline
// register behind a valid/ready handshake with synchronous flush.
module toast_alu_issue #(
    parameter logic [31:0] LINK_OFFSET = 32'd4,
    parameter bit          ILLEGAL_FWD = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] alu_op1_o,
    output logic [31:0] alu_op2_o,
    output logic        is_branch_o,
    output logic        br_invert_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_we_o,
    output logic        illegal_o
);

    // Shared ALU operation encoding (ADD must stay 0: it is the reset value).
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_SEQ  = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Register-register / immediate arithmetic share the funct3 mapping;
    // funct3 101 defaults to the logical shift, the arithmetic variant is
    // selected by funct7 at the call site.
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_to_alu = ALU_ADD;
            3'b001:  f3_to_alu = ALU_SLL;
            3'b010:  f3_to_alu = ALU_SLT;
            3'b011:  f3_to_alu = ALU_SLTU;
            3'b100:  f3_to_alu = ALU_XOR;
            3'b101:  f3_to_alu = ALU_SRL;
            3'b110:  f3_to_alu = ALU_OR;
            default: f3_to_alu = ALU_AND;
        endcase
    endfunction

    // Instruction fields and immediates.
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_u;
    logic [31:0] w_shamt;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_rd     = instr_i[11:7];
    assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign w_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign w_imm_u  = {instr_i[31:12], 12'b0};
    assign w_shamt  = {27'b0, instr_i[24:20]};

    // Decoded payload for the beat currently on the input.
    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_op1;
    logic [31:0] w_op2;
    logic        w_is_branch;
    logic        w_br_invert;
    logic        w_writes_rd;
    logic        w_rd_we;
    logic        w_illegal;

    logic        r_valid;
    logic        w_accept;

    // Handshake: a new beat may enter when the register is empty or draining.
    assign in_ready_o  = !flush_i && (!r_valid || out_ready_i);
    assign w_accept    = in_valid_i && in_ready_o;
    assign out_valid_o = r_valid;

    // Decode the instruction into ALU control, operands and sideband.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statements leaves a signal unassigned (which would infer a latch).
        w_alu_ctrl  = ALU_ADD;
        w_op1       = 32'b0;
        w_op2       = 32'b0;
        w_is_branch = 1'b0;
        w_br_invert = 1'b0;
        w_writes_rd = 1'b0;
        w_illegal   = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                w_op1       = rs1_data_i;
                w_op2       = rs2_data_i;
                w_writes_rd = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    w_alu_ctrl = f3_to_alu(w_funct3);
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b000) begin
                    w_alu_ctrl = ALU_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == 3'b101) begin
                    w_alu_ctrl = ALU_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_op1       = rs1_data_i;
                w_op2       = w_imm_i;
                w_writes_rd = 1'b1;
                w_alu_ctrl  = f3_to_alu(w_funct3);
                if (w_funct3 == 3'b001) begin
                    w_op2 = w_shamt;
                    if (w_funct7 != F7_BASE) w_illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    w_op2 = w_shamt;
                    if (w_funct7 == F7_ALT)       w_alu_ctrl = ALU_SRA;
                    else if (w_funct7 != F7_BASE) w_illegal  = 1'b1;
                end
            end
            OPC_LUI: begin
                w_op2       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_op1       = pc_i;
                w_op2       = w_imm_u;
                w_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                w_op1       = pc_i;
                w_op2       = LINK_OFFSET;
                w_writes_rd = 1'b1;
            end
            OPC_JALR: begin
                w_op1       = pc_i;
                w_op2       = LINK_OFFSET;
                w_writes_rd = 1'b1;
                if (w_funct3 != 3'b000) w_illegal = 1'b1;
            end
            OPC_LOAD: begin
                w_op1       = rs1_data_i;
                w_op2       = w_imm_i;
                w_writes_rd = 1'b1;
            end
            OPC_STORE: begin
                w_op1 = rs1_data_i;
                w_op2 = w_imm_s;
            end
            OPC_BRANCH: begin
                w_op1       = rs1_data_i;
                w_op2       = rs2_data_i;
                w_is_branch = 1'b1;
                w_br_invert = w_funct3[0];
                case (w_funct3[2:1])
                    2'b00:   w_alu_ctrl = ALU_SEQ;
                    2'b10:   w_alu_ctrl = ALU_SLT;
                    2'b11:   w_alu_ctrl = ALU_SLTU;
                    default: w_illegal  = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase

        // An undecodable word issues as a harmless ADD 0,0 with no side effects.
        if (w_illegal) begin
            w_alu_ctrl  = ALU_ADD;
            w_op1       = 32'b0;
            w_op2       = 32'b0;
            w_is_branch = 1'b0;
            w_br_invert = 1'b0;
            w_writes_rd = 1'b0;
        end
    end

    // x0 is never written.
    assign w_rd_we = w_writes_rd && (w_rd != 5'd0);

    // Pipeline register: flush wins, then accept, then drain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_valid     <= 1'b0;
            alu_ctrl_o  <= ALU_ADD;
            alu_op1_o   <= 32'b0;
            alu_op2_o   <= 32'b0;
            is_branch_o <= 1'b0;
            br_invert_o <= 1'b0;
            rd_addr_o   <= 5'b0;
            rd_we_o     <= 1'b0;
            illegal_o   <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            // A dropped illegal beat is consumed but never presented.
            r_valid     <= ILLEGAL_FWD || !w_illegal;
            alu_ctrl_o  <= w_alu_ctrl;
            alu_op1_o   <= w_op1;
            alu_op2_o   <= w_op2;
            is_branch_o <= w_is_branch;
            br_invert_o <= w_br_invert;
            rd_addr_o   <= w_rd;
            rd_we_o     <= w_rd_we;
            illegal_o   <= w_illegal;
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: doc/toast_alu_issue.md
Name: toast_alu_issue

Overview:
Registered decode/issue stage that produces the control and operands the ALU consumes.
- Per RV32I instruction: selects the ALU operation code, picks operand 1 and operand 2 (register, PC, immediate or constant), and derives branch/writeback sideband.
- Presents everything from one pipeline register with a valid/ready handshake and synchronous flush.
- Sits between register-file read and execute.

Parameters:
LINK_OFFSET, 4, constant driven on operand 2 for JAL/JALR link-address computation.
ILLEGAL_FWD, 1, 1: illegal instructions are issued with illegal_o=1; 0: they are consumed and dropped (no output beat).

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, asynchronous, active-high
in_valid_i  input  1  instruction/operand beat valid
in_ready_o  output  1  stage can accept a beat this cycle
instr_i  input  32  instruction word
pc_i  input  32  instruction address
rs1_data_i  input  32  register rs1 value
rs2_data_i  input  32  register rs2 value
flush_i  input  1  discard held beat and block acceptance this cycle
out_valid_o  output  1  issued beat valid
out_ready_i  input  1  execute accepts beat
alu_ctrl_o  output  4  ALU operation, shared ALU_* encoding
alu_op1_o  output  32  ALU operand 1
alu_op2_o  output  32  ALU operand 2
is_branch_o  output  1  conditional branch; ALU result is the condition
br_invert_o  output  1  branch taken when ALU result == 0 (BNE/BGE/BGEU)
rd_addr_o  output  5  destination register
rd_we_o  output  1  writeback enable (0 when rd==0)
illegal_o  output  1  instruction not decodable

Behaviour:
- Reset: all outputs registered and cleared to 0; out_valid_o=0; alu_ctrl_o=ALU_ADD encoding.
- Handshake: in_ready_o = !flush_i && (!out_valid_o || out_ready_i), combinational.
  - Accept when in_valid_i && in_ready_o; payload registered and out_valid_o=1 next cycle (latency 1).
  - Held beat stays stable while out_valid_o && !out_ready_i.
  - Back-to-back accept every cycle when out_ready_i=1 (full throughput).
  - Output completes with no new accept: out_valid_o=0 next cycle.
- Flush: synchronous, highest priority; out_valid_o=0 next cycle regardless of out_ready_i; no input accepted in the flush cycle.
- Async reset mid-beat: immediate clear, the held beat is lost.
- Immediates: I/S/B sign-extended to 32; U = instr[31:12]<<12; shift immediates: op2 = {27'b0, instr[24:20]}.
- Decode (opcode):
  - OP 0110011: op1=rs1, op2=rs2.
    - funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7 0100000 with funct3 000 -> SUB; with 101 -> SRA.
    - Any other funct7 -> illegal.
  - OP-IMM 0010011: op1=rs1, op2=immI. ADDI/SLTI/SLTIU/XORI/ORI/ANDI map as OP.
    - SLLI needs funct7=0000000.
    - SRLI/SRAI need funct7 0000000/0100000.
    - Otherwise illegal.
  - LUI 0110111: ADD, op1=0, op2=immU.
  - AUIPC 0010111: ADD, op1=pc, op2=immU.
  - JAL 1101111 / JALR 1100111 (funct3 must be 000): ADD, op1=pc, op2=LINK_OFFSET.
  - LOAD 0000011: ADD, op1=rs1, op2=immI. rd_we_o follows rd.
  - STORE 0100011: ADD, op1=rs1, op2=immS, rd_we_o=0.
  - BRANCH 1100011: op1=rs1, op2=rs2, is_branch_o=1, rd_we_o=0.
    - BEQ/BNE -> SEQ; BLT/BGE -> SLT; BLTU/BGEU -> SLTU.
    - br_invert_o=1 for BNE/BGE/BGEU.
    - funct3 010/011 illegal.
  - Anything else illegal.
- Illegal beat: alu_ctrl=ADD, op1=op2=0, rd_we_o=0, is_branch_o=0, illegal_o=1.
  - With ILLEGAL_FWD=0 the beat is accepted and no output beat is produced.
- rd_we_o=0 whenever rd field is 0.

Test Plan:
- Reset asserted mid-stall with out_valid_o=1 -> out_valid_o=0 immediately; in_ready_o=1 after release; all outputs 0.
- ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7, out_ready_i=1 -> next cycle: ALU_ADD, op1=5, op2=7, rd=3, rd_we=1.
  - Follow with SUB x3,x1,x2 (0x402081B3) -> ALU_SUB.
- SRAI x1,x2,3 (0x40315093) -> ALU_SRA, op2=3; ADDI x1,x0,-1 (0xFFF00093) -> op2=0xFFFFFFFF.
- AUIPC x5,0x12345 at pc=0x100 -> op1=0x100, op2=0x12345000.
  - JAL at pc=0x200 -> op1=0x200, op2=4.
  - BGEU (0x0020F463) -> ALU_SLTU, is_branch=1, br_invert=1, rd_we=0.
- out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, outputs stable.
  - Release -> one beat per cycle; flush_i pulse -> out_valid_o=0 next cycle, input held not accepted.
- instr 0xFFFFFFFF -> illegal_o=1, rd_we=0; with ILLEGAL_FWD=0 -> no out_valid_o beat, in_ready_o stays 1.
